// File: rtl/ifm_rx_sched_if.sv
// FIFO-side bundle for the rx frame scheduler: verdict FIFO, beat FIFO, and the
// good-data and control FIFOs it feeds. master = scheduler, slave = FIFO side.
`timescale 1ns/1ps
interface ifm_rx_sched_if;
    logic        info_fifo_empty;
    logic [7:0]  info_fifo_rdata;
    logic        info_fifo_rden;
    logic        data_fifo_empty;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_rden;
    logic [72:0] good_fifo_wdata;
    logic        good_fifo_wren;
    logic        good_fifo_afull;
    logic [36:0] ctrl_fifo_wdata;
    logic        ctrl_fifo_wren;
    logic        ctrl_fifo_afull;

    modport master (
        input  info_fifo_empty, info_fifo_rdata, data_fifo_empty, data_fifo_rdata,
        input  good_fifo_afull, ctrl_fifo_afull,
        output info_fifo_rden, data_fifo_rden, good_fifo_wdata, good_fifo_wren,
        output ctrl_fifo_wdata, ctrl_fifo_wren
    );

    modport slave (
        output info_fifo_empty, info_fifo_rdata, data_fifo_empty, data_fifo_rdata,
        output good_fifo_afull, ctrl_fifo_afull,
        input  info_fifo_rden, data_fifo_rden, good_fifo_wdata, good_fifo_wren,
        input  ctrl_fifo_wdata, ctrl_fifo_wren
    );
endinterface

// File: rtl/ifm_rx_sched.sv
// Receive-side frame scheduler: pops a verdict, then forwards or discards the
// frame's beats; each forwarded frame is followed by a 4-word status record.
`timescale 1ns/1ps
module ifm_rx_sched #(
    parameter bit C_DROP_BAD = 1'b1,
    parameter int C_LEN_W    = 16
) (
    input  logic           s2mm_clk,
    input  logic           sys_rst_n,
    ifm_rx_sched_if.master fifo,
    output logic [31:0]    rx_good_cnt,
    output logic [31:0]    rx_drop_cnt
);
    localparam int LW1 = C_LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COPY, S_DROP, S_STS0, S_STS1, S_STS2, S_STS3
    } state_t;

    state_t             state, next_state;
    logic               run;
    logic [7:0]         vrd;
    logic [C_LEN_W-1:0] len, len_next;
    logic [C_LEN_W:0]   len_sum;
    logic [3:0]         keep_cnt;
    logic               beat_last;
    logic               ctrl_wren_next;
    logic [36:0]        ctrl_wdata_next;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    assign beat_last = fifo.data_fifo_rdata[72];
    assign keep_cnt  = popcount8(fifo.data_fifo_rdata[71:64]);
    assign len_sum   = {1'b0, len} + LW1'(keep_cnt);
    assign len_next  = len_sum[C_LEN_W] ? '1 : len_sum[C_LEN_W-1:0];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        next_state           = state;
        fifo.info_fifo_rden  = 1'b0;
        fifo.data_fifo_rden  = 1'b0;
        fifo.good_fifo_wren  = 1'b0;
        fifo.good_fifo_wdata = '0;
        case (state)
            S_IDLE: begin
                // run keeps the pop strobe low while reset is held.
                if (run && !fifo.info_fifo_empty && !fifo.ctrl_fifo_afull && !fifo.good_fifo_afull) begin
                    fifo.info_fifo_rden = 1'b1;
                    next_state = (fifo.info_fifo_rdata[0] || !C_DROP_BAD) ? S_COPY : S_DROP;
                end
            end
            S_COPY: begin
                if (!fifo.data_fifo_empty && !fifo.good_fifo_afull) begin
                    fifo.data_fifo_rden  = 1'b1;
                    fifo.good_fifo_wren  = 1'b1;
                    fifo.good_fifo_wdata = fifo.data_fifo_rdata;
                    if (beat_last) next_state = S_STS0;
                end
            end
            S_DROP: begin
                if (!fifo.data_fifo_empty) begin
                    fifo.data_fifo_rden = 1'b1;
                    if (beat_last) next_state = S_IDLE;
                end
            end
            S_STS0:  next_state = S_STS1;
            S_STS1:  next_state = S_STS2;
            S_STS2:  next_state = S_STS3;
            S_STS3:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status words are registered on entry to each STS state, so word N is on
    // the bus while the FSM sits in STSn.
    always_comb begin
        ctrl_wren_next  = 1'b1;
        ctrl_wdata_next = '0;
        case (next_state)
            S_STS0:  ctrl_wdata_next = {1'b0, 4'hF, 32'h5000_0000};
            S_STS1:  ctrl_wdata_next = {1'b0, 4'hF, 24'h0, vrd};
            S_STS2:  ctrl_wdata_next = {1'b0, 4'hF, 16'h0, 16'(len)};
            S_STS3:  ctrl_wdata_next = {1'b1, 4'hF, 16'h0, rx_good_cnt[15:0]};
            default: ctrl_wren_next  = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge s2mm_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                <= S_IDLE;
            run                  <= 1'b0;
            vrd                  <= '0;
            len                  <= '0;
            rx_good_cnt          <= '0;
            rx_drop_cnt          <= '0;
            fifo.ctrl_fifo_wren  <= 1'b0;
            fifo.ctrl_fifo_wdata <= '0;
        end else begin
            state                <= next_state;
            run                  <= 1'b1;
            fifo.ctrl_fifo_wren  <= ctrl_wren_next;
            fifo.ctrl_fifo_wdata <= ctrl_wdata_next;
            if (fifo.info_fifo_rden) begin
                vrd <= fifo.info_fifo_rdata;
                len <= '0;
            end
            if (state == S_COPY && fifo.data_fifo_rden) len <= len_next;
            if (state == S_COPY && next_state == S_STS0) rx_good_cnt <= rx_good_cnt + 32'd1;
            if (state == S_DROP && fifo.data_fifo_rden && beat_last) rx_drop_cnt <= rx_drop_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_ifm_rx_sched.sv
// Bench for ifm_rx_sched: lane 0 discards bad frames, lane 1 forwards all;
// FWFT FIFO models feed each lane and a per-lane monitor scores every write.
`timescale 1ns/1ps
module tb_ifm_rx_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tag    = 0;

    logic [7:0]  info_q   [2][$];
    logic [72:0] data_q   [2][$];
    logic [72:0] exp_good [2][$];
    logic [36:0] exp_ctrl [2][$];
    bit          good_af  [2];
    bit          ctrl_af  [2];
    bit          bp_en;

    logic [31:0]  good_cnt     [2];
    logic [31:0]  drop_cnt     [2];
    logic         info_rden_mon[2];
    logic [113:0] out_vec      [2];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        ifm_rx_sched_if bus();

        ifm_rx_sched #(.C_DROP_BAD(g == 0), .C_LEN_W(16)) dut (
            .s2mm_clk    (clk),
            .sys_rst_n   (rst_n),
            .fifo        (bus.master),
            .rx_good_cnt (good_cnt[g]),
            .rx_drop_cnt (drop_cnt[g])
        );

        assign info_rden_mon[g] = bus.info_fifo_rden;
        assign out_vec[g] = {bus.info_fifo_rden, bus.data_fifo_rden, bus.good_fifo_wren,
                             bus.good_fifo_wdata, bus.ctrl_fifo_wren, bus.ctrl_fifo_wdata};

        initial begin : model
            logic ip, dp, stall;
            bus.info_fifo_empty = 1'b1;
            bus.info_fifo_rdata = '0;
            bus.data_fifo_empty = 1'b1;
            bus.data_fifo_rdata = '0;
            bus.good_fifo_afull = 1'b0;
            bus.ctrl_fifo_afull = 1'b0;
            forever begin
                @(negedge clk);
                ip = bus.info_fifo_rden;
                dp = bus.data_fifo_rden;
                check($sformatf("lane%0d_handshake", g),
                      {125'b0, ip & bus.info_fifo_empty, dp & bus.data_fifo_empty,
                       bus.good_fifo_wren & bus.good_fifo_afull}, 128'd0);
                if (bus.good_fifo_wren) begin
                    if (exp_good[g].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL lane%0d_good_unexpected: got %0h required no write", g, bus.good_fifo_wdata);
                    end else
                        check($sformatf("lane%0d_good_beat", g), 128'(bus.good_fifo_wdata), 128'(exp_good[g].pop_front()));
                end
                if (bus.ctrl_fifo_wren) begin
                    if (exp_ctrl[g].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL lane%0d_ctrl_unexpected: got %0h required no write", g, bus.ctrl_fifo_wdata);
                    end else
                        check($sformatf("lane%0d_ctrl_word", g), 128'(bus.ctrl_fifo_wdata), 128'(exp_ctrl[g].pop_front()));
                end
                @(posedge clk);
                #1;
                if (ip && info_q[g].size() != 0) void'(info_q[g].pop_front());
                if (dp && data_q[g].size() != 0) void'(data_q[g].pop_front());
                stall = bp_en && ($urandom_range(0, 2) == 0);
                bus.good_fifo_afull = good_af[g] || (bp_en && ($urandom_range(0, 3) == 0));
                bus.ctrl_fifo_afull = ctrl_af[g];
                bus.info_fifo_empty = (info_q[g].size() == 0);
                bus.info_fifo_rdata = (info_q[g].size() != 0) ? info_q[g][0] : 8'h00;
                bus.data_fifo_empty = (data_q[g].size() == 0) || stall;
                bus.data_fifo_rdata = (data_q[g].size() != 0) ? data_q[g][0] : 73'd0;
            end
        end
    end

    function automatic logic [36:0] sts(input logic last, input logic [31:0] d);
        return {last, 4'hF, d};
    endfunction

    // Queues one frame; exp_len / exp_cnt are the hand-computed W2 / W3 payloads.
    task automatic send_frame(input int g, input logic [7:0] vrd, input int n,
                              input logic [7:0] last_keep, input int zero_idx, input bit fwd,
                              input logic [15:0] exp_len, input logic [15:0] exp_cnt);
        logic [72:0] b;
        tag++;
        info_q[g].push_back(vrd);
        for (int i = 0; i < n; i++) begin
            b[63:0]  = {tag[7:0], i[7:0], 16'hC0DE, 32'(tag * 7 + i * 13)};
            b[71:64] = (i == n - 1) ? last_keep : ((i == zero_idx) ? 8'h00 : 8'hFF);
            b[72]    = (i == n - 1);
            data_q[g].push_back(b);
            if (fwd) exp_good[g].push_back(b);
        end
        if (fwd) begin
            exp_ctrl[g].push_back(sts(1'b0, 32'h5000_0000));
            exp_ctrl[g].push_back(sts(1'b0, {24'h0, vrd}));
            exp_ctrl[g].push_back(sts(1'b0, {16'h0, exp_len}));
            exp_ctrl[g].push_back(sts(1'b1, {16'h0, exp_cnt}));
        end
    endtask

    task automatic wait_drain(input int g, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (info_q[g].size() == 0) && (data_q[g].size() == 0) &&
                   (exp_good[g].size() == 0) && (exp_ctrl[g].size() == 0);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_drain_timeout: got %0d beats %0d words pending required 0", name,
                     exp_good[g].size(), exp_ctrl[g].size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        bp_en   = 1'b0;
        good_af = '{1'b0, 1'b0};
        ctrl_af = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("reset_outputs_lane0", 128'(out_vec[0]), 128'd0);
        check("reset_outputs_lane1", 128'(out_vec[1]), 128'd0);
        check("reset_counters", 128'({good_cnt[0], drop_cnt[0], good_cnt[1], drop_cnt[1]}), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // 64-byte good frame
        send_frame(0, 8'h01, 8, 8'hFF, -1, 1'b1, 16'h0040, 16'h0001);
        wait_drain(0, "good64");
        check("good64_cnt", 128'(good_cnt[0]), 128'd1);

        // bad frame dropped, then good frame with a tkeep=0 beat (8+0+4 bytes)
        send_frame(0, 8'h02, 3, 8'hFF, -1, 1'b0, 16'h0000, 16'h0000);
        send_frame(0, 8'h01, 3, 8'h0F, 1, 1'b1, 16'h000C, 16'h0002);
        wait_drain(0, "drop");
        check("drop_cnt", 128'(drop_cnt[0]), 128'd1);
        check("drop_good_cnt", 128'(good_cnt[0]), 128'd2);

        // forward-all lane: 61-byte frame, then single-beat bad-verdict frame
        send_frame(1, 8'h04, 8, 8'h1F, -1, 1'b1, 16'h003D, 16'h0001);
        send_frame(1, 8'h02, 1, 8'h03, -1, 1'b1, 16'h0002, 16'h0002);
        wait_drain(1, "fwd_all");
        check("fwd_all_good_cnt", 128'(good_cnt[1]), 128'd2);
        check("fwd_all_drop_cnt", 128'(drop_cnt[1]), 128'd0);

        // random backpressure on good afull and data empty
        bp_en = 1'b1;
        send_frame(0, 8'h01, 5, 8'h80, -1, 1'b1, 16'h0021, 16'h0003);
        send_frame(0, 8'h08, 4, 8'hFF, -1, 1'b0, 16'h0000, 16'h0000);
        send_frame(0, 8'h01, 2, 8'h00, -1, 1'b1, 16'h0008, 16'h0004);
        wait_drain(0, "backpressure");
        bp_en = 1'b0;
        wait_drain(0, "backpressure_idle");
        check("bp_good_cnt", 128'(good_cnt[0]), 128'd4);
        check("bp_drop_cnt", 128'(drop_cnt[0]), 128'd2);

        // ctrl FIFO afull holds off the verdict pop
        @(posedge clk);
        ctrl_af[0] = 1'b1;
        send_frame(0, 8'h01, 1, 8'hFF, -1, 1'b1, 16'h0008, 16'h0005);
        repeat (6) begin
            @(negedge clk);
            check("ctrl_afull_no_pop", 128'(info_rden_mon[0]), 128'd0);
        end
        @(posedge clk);
        ctrl_af[0] = 1'b0;
        @(negedge clk);
        check("pop_after_afull", 128'(info_rden_mon[0]), 128'd1);
        wait_drain(0, "ctrl_afull");
        check("ctrl_afull_good_cnt", 128'(good_cnt[0]), 128'd5);

        // reset while the third beat of a frame is being copied
        send_frame(0, 8'h01, 6, 8'hFF, -1, 1'b1, 16'h0030, 16'h0006);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (data_q[0].size() <= 4) break;
        end
        check("beat3_reached", 128'(data_q[0].size()), 128'd4);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", 128'(out_vec[0]), 128'd0);
        check("midframe_reset_counters", 128'({good_cnt[0], drop_cnt[0]}), 128'd0);
        info_q[0].delete();
        data_q[0].delete();
        exp_good[0].delete();
        exp_ctrl[0].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_frame(0, 8'h01, 1, 8'h01, -1, 1'b1, 16'h0001, 16'h0001);
        wait_drain(0, "after_reset");
        check("after_reset_good_cnt", 128'(good_cnt[0]), 128'd1);
        check("after_reset_drop_cnt", 128'(drop_cnt[0]), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifm_rx_sched.md
Name: ifm_rx_sched

Overview:
- Receive-side frame scheduler in the s2mm clock domain.
- Pops one 8-bit per-frame verdict from the info FIFO, then moves that frame's 73-bit beats from the data FIFO.
- Good frames are copied into the good FIFO; bad frames are discarded.
- After each forwarded frame, writes a 4-word status record into the ctrl FIFO. This sequences the whole rx_clk→s2mm handoff datapath.

Parameters:
- C_DROP_BAD, 1: 1 = discard frames whose verdict bit0=0; 0 = forward every frame with its status.
- C_LEN_W, 16: width of the per-frame byte counter; saturates at all-ones.

Ports:
- s2mm_clk  in  1  sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- info_fifo_empty  in  1  info FIFO empty.
- info_fifo_rdata  in  8  verdict, first-word-fall-through: bit0 good, bit1 fcs_err, bit2 len_err, bit3 overflow, [7:4] reserved.
- info_fifo_rden  out  1  pop verdict.
- data_fifo_empty  in  1  data FIFO empty.
- data_fifo_rdata  in  73  FWFT beat: [63:0] data, [71:64] tkeep, [72] tlast.
- data_fifo_rden  out  1  pop beat.
- good_fifo_wdata  out  73  beat to good FIFO.
- good_fifo_wren  out  1  write good FIFO.
- good_fifo_afull  in  1  good FIFO prog_full.
- ctrl_fifo_wdata  out  37  status word: [31:0] data, [35:32] keep, [36] last.
- ctrl_fifo_wren  out  1  write ctrl FIFO.
- ctrl_fifo_afull  in  1  ctrl FIFO prog_full.
- rx_good_cnt  out  32  frames forwarded; wraps.
- rx_drop_cnt  out  32  frames discarded; wraps.

Behaviour:
- Reset (async, sys_rst_n=0):
  - FSM goes to IDLE; all outputs 0; counters 0; len and latched verdict cleared.
  - Reset mid-frame abandons the frame; the FIFOs are reset by their own reset.
- States:
  - IDLE: when ~info_fifo_empty && ~ctrl_fifo_afull && ~good_fifo_afull, assert info_fifo_rden for 1 cycle and latch info_fifo_rdata into vrd. Go to COPY if vrd[0]=1 or C_DROP_BAD=0, else DROP. Clear len.
  - COPY: data_fifo_rden = good_fifo_wren = ~data_fifo_empty && ~good_fifo_afull (combinational). good_fifo_wdata = data_fifo_rdata. Each accepted beat adds popcount(tkeep) to len, saturating at 2^C_LEN_W-1. An accepted beat with tlast goes to STS0.
  - DROP: data_fifo_rden = ~data_fifo_empty, no good FIFO write. Accepted tlast beat: rx_drop_cnt++, go to IDLE.
  - STS0..STS3: one registered ctrl FIFO write per cycle, unconditionally, since IDLE's afull check guarantees 4 free entries (prog_full margin ≥4). Keep=4'hF on all words.
    - W0 = 32'h5000_0000, last=0.
    - W1 = {24'h0, vrd}, last=0.
    - W2 = {16'h0, len zero-extended/truncated to 16}, last=0.
    - W3 = {16'h0, rx_good_cnt[15:0] value after increment}, last=1.
    - rx_good_cnt increments entering STS0. STS3 returns to IDLE.
- Latency:
  - Verdict pop to first beat move is 1 cycle.
  - Last beat to first status word is 1 cycle.
  - Status record is 4 consecutive cycles.
  - Minimum gap frame-to-frame is 1 IDLE cycle.
- Boundaries:
  - Data FIFO empty mid-frame: stall with no pop and no write.
  - good_fifo_afull mid-COPY: stall.
  - Info present but afull in IDLE: wait; no pop.
  - Beats are never reordered or duplicated.
  - Single-beat frame (tlast on first beat) is valid.
  - tkeep=0 beat adds 0 to len.
  - data_fifo_rden is never asserted while data_fifo_empty=1; info_fifo_rden is never asserted while info_fifo_empty=1.

Test Plan:
- Good 64-byte frame: verdict 8'h01 + 8 beats of tkeep FF, last on beat 8 → 8 good FIFO writes identical to input. Status words 50000000, 00000001, 00000040, 00000001 with last on W3. rx_good_cnt=1.
- Bad frame, C_DROP_BAD=1: verdict 8'h02 + 3 beats → 3 data pops, 0 good/ctrl writes, rx_drop_cnt=1. A following good frame is forwarded normally.
- C_DROP_BAD=0 with verdict 8'h04 and a 61-byte frame (last tkeep 8'h1F) → frame forwarded. W1=00000004, W2=0000003D.
- Backpressure: toggle good_fifo_afull and data_fifo_empty randomly mid-frame → no write while afull, no pop while empty, byte-exact order, len correct.
- ctrl_fifo_afull=1 with info pending → info_fifo_rden stays 0. Deassert → verdict pop on next cycle.
- Assert sys_rst_n=0 during COPY beat 3 → all outputs 0 immediately. After release: IDLE, counters 0.
